// File: rtl/redundant_resolver.sv
// redundant_resolver
//   Word-serial carry resolution for the compressor multiplier output. A
//   product arrives as NUM_WORDS redundant digits of BIT_LEN bits, where
//   digit j has weight 2^(WORD_LEN*j). One digit is folded per clock with the
//   running carry, which produces one canonical WORD_LEN-bit word per clock.
//   The resolved product is then offered over a valid/ready handshake.
//
// Ports
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset
//   in_valid      in_digits holds a redundant product
//   in_ready      block can accept a product (high only in IDLE)
//   in_digits     NUM_WORDS x BIT_LEN redundant digits, digit 0 in the LSBs
//   out_valid     out_data holds a resolved product (high only in DONE)
//   out_ready     consumer takes out_data
//   out_data      NUM_WORDS x WORD_LEN resolved words, word 0 in the LSBs
//   out_overflow  final carry was nonzero (only with the macro below)
//
// Build option
//   REDUNDANT_RESOLVER_OVERFLOW_EN adds the out_overflow port. Without it,
//   the final carry is dropped and the result is simply truncated.
module redundant_resolver #(
    parameter int NUM_WORDS = 34,
    parameter int BIT_LEN   = 17,
    parameter int WORD_LEN  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_WORDS*BIT_LEN-1:0]  in_digits,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_WORDS*WORD_LEN-1:0] out_data
`ifdef REDUNDANT_RESOLVER_OVERFLOW_EN
    ,
    output logic                          out_overflow
`endif
);

    // The carry out of BIT_LEN+1-bit sum shifted by WORD_LEN never exceeds
    // 2^(BIT_LEN-WORD_LEN), so this width always holds it.
    localparam int CW    = BIT_LEN - WORD_LEN + 1;
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q;
    logic [CW-1:0]                   carry_q;
    logic [NUM_WORDS*BIT_LEN-1:0]    digits_q;
    logic [NUM_WORDS*WORD_LEN-1:0]   data_q;

    logic [BIT_LEN-1:0]              cur_digit;
    logic [BIT_LEN:0]                sum;
    logic [CW-1:0]                   carry_nxt;
    logic                            accept;
    logic                            last_word;

    // Handshake outputs depend only on the registered state, so there is no
    // combinational path from in_valid or out_ready.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;

    assign accept    = in_valid && in_ready;
    assign last_word = (idx_q == LAST_IDX);

    always_comb begin
        cur_digit = digits_q[idx_q*BIT_LEN +: BIT_LEN];
        sum       = {1'b0, cur_digit} + (BIT_LEN+1)'(carry_q);
        carry_nxt = sum[BIT_LEN:WORD_LEN];
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)                state_d = RUN;
            RUN:  if (last_word)             state_d = DONE;
            DONE: if (out_valid && out_ready) state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            carry_q  <= '0;
            digits_q <= '0;
            data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        digits_q <= in_digits;
                        idx_q    <= '0;
                        carry_q  <= '0;
                    end
                end
                RUN: begin
                    data_q[idx_q*WORD_LEN +: WORD_LEN] <= sum[WORD_LEN-1:0];
                    carry_q <= carry_nxt;
                    // Index stops at the last word; it is reloaded on accept.
                    if (!last_word) idx_q <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef REDUNDANT_RESOLVER_OVERFLOW_EN
    logic ovf_q;
    assign out_overflow = ovf_q;

    // Captured from the carry out of the last word as DONE is entered and
    // held until the next product finishes.
    always_ff @(posedge clk) begin
        if (rst)                           ovf_q <= 1'b0;
        else if (state_q == RUN && last_word) ovf_q <= (carry_nxt != '0);
    end
`endif

endmodule
